// File: rtl/barrido_teclado_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, matrix geometry
// and one-hot decoding of row/column vectors.
package teclado_pkg;

    typedef enum logic [1:0] {
        BARRIDO    = 2'd0,
        CONFIRMA   = 2'd1,
        PRESIONADA = 2'd2
    } estado_t;

    localparam int NUM_FILAS    = 4;
    localparam int NUM_COLUMNAS = 4;
    localparam int TECLA_W      = 4;
    localparam int IDX_W        = 2;

    function automatic logic [IDX_W-1:0] onehot_a_indice(input logic [3:0] v);
        logic [IDX_W-1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic es_fila_unica(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/barrido_teclado_sincronizador.sv
// sincronizador: two-flop synchronizer for a bus of independent asynchronous
// level signals (keypad rows). Each bit is synchronized on its own.
module sincronizador #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/barrido_teclado.sv
// barrido_teclado: 4x4 keypad scanner with debounce and a valid/ack handshake.
// Define TECLADO_REPETICION_EN to enable auto-repeat while a key stays held.
module barrido_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 8
`ifdef TECLADO_REPETICION_EN
    ,
    parameter int REPEAT_TICKS = 250
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_FILAS-1:0]    filas,
    output logic [NUM_COLUMNAS-1:0] columnas,
    output logic [TECLA_W-1:0]      tecla,
    output logic                    tecla_valida,
    input  logic                    tecla_leida
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CNT);

    logic [NUM_FILAS-1:0]    filas_s;
    logic [DIV_W-1:0]        div_q;
    logic [DIV_W-1:0]        div_d;
    logic                    tick_s;
    logic                    fila_unica_s;
    logic                    fila_misma_s;
    logic                    carga_ok_s;
    logic [NUM_COLUMNAS-1:0] rot_s;
    logic [TECLA_W-1:0]      codigo_s;

    estado_t                 estado_q;
    logic [NUM_COLUMNAS-1:0] columnas_q;
    logic [IDX_W-1:0]        fila_q;
    logic [CNT_W-1:0]        deb_q;
    logic [CNT_W-1:0]        rel_q;
    logic [TECLA_W-1:0]      tecla_q;
    logic                    valida_q;

`ifdef TECLADO_REPETICION_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_TICKS);
    logic [REP_W-1:0]        rep_q;
`endif

    sincronizador #(.W(NUM_FILAS)) u_sinc (
        .clk   (clk),
        .reset (reset),
        .d_i   (filas),
        .q_o   (filas_s)
    );

    assign tick_s       = (div_q == DIV_MAX);
    assign fila_unica_s = es_fila_unica(filas_s);
    assign fila_misma_s = fila_unica_s && filas_s[fila_q];
    assign rot_s        = {columnas_q[NUM_COLUMNAS-2:0], columnas_q[NUM_COLUMNAS-1]};
    assign codigo_s     = {fila_q, onehot_a_indice(columnas_q)};
    // An acknowledge on the same edge frees the slot, so the new code may load.
    assign carga_ok_s   = !valida_q || tecla_leida;

    // Scan-tick divider next value.
    always_comb begin
        div_d = div_q;
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Scan/debounce FSM with registered outputs; a later load overrides the ack clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= BARRIDO;
            columnas_q <= 4'b0001;
            fila_q     <= 2'd0;
            deb_q      <= '0;
            rel_q      <= '0;
            tecla_q    <= 4'd0;
            valida_q   <= 1'b0;
`ifdef TECLADO_REPETICION_EN
            rep_q      <= '0;
`endif
        end else begin
            if (tecla_leida) begin
                valida_q <= 1'b0;
            end
            if (tick_s) begin
                case (estado_q)
                    BARRIDO: begin
                        if (fila_unica_s) begin
                            fila_q   <= onehot_a_indice(filas_s);
                            deb_q    <= '0;
                            estado_q <= CONFIRMA;
                        end else begin
                            columnas_q <= rot_s;
                        end
                    end
                    CONFIRMA: begin
                        if (fila_misma_s) begin
                            if ((deb_q + CNT_W'(1)) == DEB_MAX) begin
                                estado_q <= PRESIONADA;
                                rel_q    <= '0;
`ifdef TECLADO_REPETICION_EN
                                rep_q    <= '0;
`endif
                                if (carga_ok_s) begin
                                    tecla_q  <= codigo_s;
                                    valida_q <= 1'b1;
                                end
                            end else begin
                                deb_q <= deb_q + CNT_W'(1);
                            end
                        end else begin
                            columnas_q <= rot_s;
                            estado_q   <= BARRIDO;
                        end
                    end
                    PRESIONADA: begin
                        if (filas_s == 4'd0) begin
                            if ((rel_q + CNT_W'(1)) == DEB_MAX) begin
                                rel_q      <= '0;
                                columnas_q <= rot_s;
                                estado_q   <= BARRIDO;
                            end else begin
                                rel_q <= rel_q + CNT_W'(1);
                            end
                        end else begin
                            rel_q <= '0;
                        end
`ifdef TECLADO_REPETICION_EN
                        if (filas_s[fila_q]) begin
                            if ((rep_q + REP_W'(1)) == REP_MAX) begin
                                rep_q <= '0;
                                if (carga_ok_s) begin
                                    tecla_q  <= codigo_s;
                                    valida_q <= 1'b1;
                                end
                            end else begin
                                rep_q <= rep_q + REP_W'(1);
                            end
                        end
`endif
                    end
                    default: begin
                        estado_q   <= BARRIDO;
                        columnas_q <= 4'b0001;
                    end
                endcase
            end
        end
    end

    assign columnas     = columnas_q;
    assign tecla        = tecla_q;
    assign tecla_valida = valida_q;

endmodule

// File: tb/tb_barrido_teclado.sv
// Directed bench for barrido_teclado with a keypad model (SCAN_DIV=4, DEBOUNCE_CNT=3).
// Define TECLADO_REPETICION_EN to exercise auto-repeat with REPEAT_TICKS=5.
`timescale 1ns/1ps
module tb_barrido_teclado;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        tecla_leida;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  tecla;
    logic        tecla_valida;
    logic [15:0] teclas;

    int   total = 0;
    int   bad = 0;
    int   cargas = 0;
    logic val_prev = 1'b0;

    always #5 clk = ~clk;

    barrido_teclado #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
`ifdef TECLADO_REPETICION_EN
        ,
        .REPEAT_TICKS (REP)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .filas        (filas),
        .columnas     (columnas),
        .tecla        (tecla),
        .tecla_valida (tecla_valida),
        .tecla_leida  (tecla_leida)
    );

    // Keypad: key (r,c) connects driven column c to row r.
    always_comb begin
        filas = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (teclas[r*4+c] && columnas[c]) filas[r] = 1'b1;
            end
        end
    end

    // Count rising edges of tecla_valida.
    always @(negedge clk) begin
        if (tecla_valida && !val_prev) cargas <= cargas + 1;
        val_prev <= tecla_valida;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valida(input int lim, output int n);
        n = 0;
        while (!tecla_valida && n < lim) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_col(input logic [3:0] col, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            prev = columnas;
            step(1);
            if (columnas == col && prev != col) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack();
        tecla_leida = 1'b1;
        step(1);
        tecla_leida = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b1; teclas = 16'h0000; tecla_leida = 1'b0;
        step(2);
        total++; if (columnas !== 4'b0001) begin bad++; $display("FAIL reset_col: got %b want 0001", columnas); end
        total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tecla_valida); end
        total++; if (tecla !== 4'd0) begin bad++; $display("FAIL reset_tecla: got %0d want 0", tecla); end
        reset = 1'b0;
        step(3);
        total++; if (columnas !== 4'b0001) begin bad++; $display("FAIL pre_tick_col: got %b want 0001", columnas); end
        exp = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step(k == 0 ? 1 : 4);
            exp = {exp[2:0], exp[3]};
            total++; if (columnas !== exp) begin bad++; $display("FAIL rotate_%0d: got %b want %b", k, columnas, exp); end
        end
    endtask

    task automatic test_clean_press();
        int n;
        int c0;
        c0 = cargas;
        teclas = 16'h0200;
        wait_valida(40, n);
        total++; if (tecla_valida !== 1'b1) begin bad++; $display("FAIL clean_latency: valid %b after %0d cycles want 1", tecla_valida, n); end
        total++; if (tecla !== 4'd9) begin bad++; $display("FAIL clean_code: got %0d want 9", tecla); end
        step(40 - n);
        total++; if (cargas - c0 !== 1) begin bad++; $display("FAIL clean_once: got %0d loads want 1", cargas - c0); end
        total++; if (tecla_valida !== 1'b1) begin bad++; $display("FAIL clean_hold_valid: got %b want 1", tecla_valida); end
        ack();
        total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL clean_ack: got %b want 0", tecla_valida); end
        teclas = 16'h0000;
        step(24);
        total++; if (cargas - c0 !== 1) begin bad++; $display("FAIL clean_release: got %0d loads want 1", cargas - c0); end
    endtask

    task automatic test_bounce();
        bit ok;
        int n;
        wait_col(4'b1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL bounce_align: column 1000 not seen, got %b", columnas); end
        teclas = 16'h0008;
        step(4);
        teclas = 16'h0000;
        step(4);
        total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL bounce_no_code: got %b want 0", tecla_valida); end
        total++; if (columnas !== 4'b0001) begin bad++; $display("FAIL bounce_reject_rot: got %b want 0001", columnas); end
        teclas = 16'h0008;
        wait_valida(40, n);
        total++; if (tecla_valida !== 1'b1) begin bad++; $display("FAIL bounce_latency: valid %b after %0d cycles want 1", tecla_valida, n); end
        total++; if (tecla !== 4'd3) begin bad++; $display("FAIL bounce_code: got %0d want 3", tecla); end
        ack();
        teclas = 16'h0000;
        step(24);
    endtask

    task automatic test_two_rows();
        bit ok;
        int c0;
        logic [3:0] prev;
        c0 = cargas;
        teclas = 16'h1010;
        wait_col(4'b0001, ok);
        total++; if (!ok) begin bad++; $display("FAIL two_align: column 0001 not seen, got %b", columnas); end
        for (int k = 0; k < 8; k++) begin
            prev = columnas;
            step(4);
            total++; if (columnas !== {prev[2:0], prev[3]}) begin bad++; $display("FAIL two_rotate_%0d: got %b want %b", k, columnas, {prev[2:0], prev[3]}); end
        end
        total++; if (cargas - c0 !== 0 || tecla_valida !== 1'b0) begin bad++; $display("FAIL two_no_code: loads %0d valid %b want 0 0", cargas - c0, tecla_valida); end
        teclas = 16'h0000;
        step(8);
    endtask

    task automatic test_pending();
        bit ok;
        int n;
        teclas = 16'h0020;
        wait_valida(40, n);
        total++; if (tecla_valida !== 1'b1 || tecla !== 4'd5) begin bad++; $display("FAIL pend_first: valid %b code %0d want 1 5", tecla_valida, tecla); end
        teclas = 16'h0000;
        step(24);
        wait_col(4'b0100, ok);
        total++; if (!ok) begin bad++; $display("FAIL pend_align1: column 0100 not seen, got %b", columnas); end
        teclas = 16'h0400;
        step(20);
        total++; if (tecla !== 4'd5 || tecla_valida !== 1'b1) begin bad++; $display("FAIL pend_drop: code %0d valid %b want 5 1", tecla, tecla_valida); end
        teclas = 16'h0000;
        step(24);
        wait_col(4'b0100, ok);
        total++; if (!ok) begin bad++; $display("FAIL pend_align2: column 0100 not seen, got %b", columnas); end
        teclas = 16'h0400;
        step(15);
        total++; if (tecla !== 4'd5) begin bad++; $display("FAIL pend_before_load: got %0d want 5", tecla); end
        ack();
        total++; if (tecla_valida !== 1'b1) begin bad++; $display("FAIL pend_load_wins_valid: got %b want 1", tecla_valida); end
        total++; if (tecla !== 4'd10) begin bad++; $display("FAIL pend_load_wins_code: got %0d want 10", tecla); end
        ack();
        total++; if (tecla_valida !== 1'b0) begin bad++; $display("FAIL pend_final_ack: got %b want 0", tecla_valida); end
        teclas = 16'h0000;
        step(24);
    endtask

`ifdef TECLADO_REPETICION_EN
    task automatic test_repeat();
        int n;
        teclas = 16'h0001;
        wait_valida(40, n);
        total++; if (tecla_valida !== 1'b1 || tecla !== 4'd0) begin bad++; $display("FAIL rep_first: valid %b code %0d want 1 0", tecla_valida, tecla); end
        for (int k = 0; k < 2; k++) begin
            ack();
            n = 1;
            while (!tecla_valida && n < 40) begin
                step(1);
                n++;
            end
            total++; if (n !== REP * SCAN_DIV) begin bad++; $display("FAIL rep_interval_%0d: got %0d cycles want %0d", k, n, REP * SCAN_DIV); end
            total++; if (tecla !== 4'd0) begin bad++; $display("FAIL rep_code_%0d: got %0d want 0", k, tecla); end
        end
        ack();
        teclas = 16'h0000;
        step(24);
    endtask
`else
    task automatic test_single_code();
        int n;
        int c0;
        c0 = cargas;
        teclas = 16'h0001;
        wait_valida(40, n);
        total++; if (tecla_valida !== 1'b1 || tecla !== 4'd0) begin bad++; $display("FAIL single_first: valid %b code %0d want 1 0", tecla_valida, tecla); end
        ack();
        step(60);
        total++; if (tecla_valida !== 1'b0 || cargas - c0 !== 1) begin bad++; $display("FAIL single_no_repeat: valid %b loads %0d want 0 1", tecla_valida, cargas - c0); end
        teclas = 16'h0000;
        step(24);
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        teclas = 16'h8000;
        wait_valida(40, n);
        total++; if (tecla_valida !== 1'b1 || tecla !== 4'd15) begin bad++; $display("FAIL mid_code: valid %b code %0d want 1 15", tecla_valida, tecla); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        teclas = 16'h0000;
        total++; if (columnas !== 4'b0001 || tecla_valida !== 1'b0 || tecla !== 4'd0) begin bad++; $display("FAIL mid_reset: col %b valid %b code %0d want 0001 0 0", columnas, tecla_valida, tecla); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_two_rows();
        test_pending();
`ifdef TECLADO_REPETICION_EN
        test_repeat();
`else
        test_single_code();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
